r200lsu: RTL
============

Name: r200lsu

Overview:
- Multi-cycle load/store unit for the MEM stage of the r200 pipeline.
- Sits between ex_mem_reg and mem_wb_reg and replaces the single-cycle data-memory path.
- Consumes the MEM-stage address, store data and func3, and drives a request/grant/rvalid data bus with variable latency.
- Returns aligned, sign/zero-extended load data, and stalls the pipeline while a bus transaction is outstanding.

Parameters:
- TIMEOUT, 64: maximum cycles in WAIT before the load is aborted with bus_err.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- mem_valid  in  1  MEM stage holds a live instruction (not a bubble).
- mem_memrd  in  1  instruction is a load.
- mem_memwr  in  1  instruction is a store.
- mem_func3  in  3  RV32I width/sign code.
- mem_alu_res  in  32  effective byte address.
- mem_rs2o  in  32  store data.
- dmem_out  out  32  extended load result, consumed by mem_wb_reg.
- stall  out  1  freezes the PC, if_id, id_ex and ex_mem registers.
- misalign  out  1  one-cycle exception pulse (misaligned or illegal func3).
- bus_err  out  1  sticky flag: load timed out.
- bus_req  out  1  bus request.
- bus_we  out  1  request is a write.
- bus_addr  out  32  word address, bits [1:0] = 0.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  write data, lane-replicated.
- bus_gnt  in  1  request accepted this cycle.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  32  read data.

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE.
- Reset (asynchronous, effective immediately, including mid-transaction):
  - state = IDLE; bus_req, bus_we, bus_be, bus_addr, bus_wdata, dmem_out, misalign, bus_err and the timeout counter all = 0.
  - An outstanding request is dropped; a late rvalid after reset is ignored.
- start = mem_valid & (mem_memrd | mem_memwr). mem_memrd and mem_memwr both high is treated as a store.
- stall = (IDLE & start) | REQ | WAIT. stall is combinational, so the op is frozen in ex_mem_reg from its first cycle. stall is 0 in DONE.
- IDLE:
  - start with legal, aligned op: latch addr/we/be/wdata/func3/addr[1:0] and go to REQ.
  - start with illegal or misaligned op: go to DONE with an exception. No bus activity.
  - No start: stay in IDLE; dmem_out holds its value.
- Legal func3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal.
- Misaligned: halfword with addr[0] = 1; word with addr[1:0] != 0.
- Byte enables / write data:
  - SB: be = 0001 << addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{rs2[15:0]}}.
  - SW: be = 1111, wdata = rs2.
  - Loads: be = 1111.
- REQ:
  - bus_req = 1; addr/we/be/wdata held stable until bus_gnt.
  - On gnt, store: go to DONE (store completes on grant).
  - On gnt, load, with rvalid in the same cycle: capture data and go to DONE.
  - On gnt, load, otherwise: go to WAIT with counter cleared.
- WAIT:
  - bus_req = 0; counter increments every cycle.
  - On rvalid: select lane by latched addr[1:0], extend per func3 (LB/LH sign-extend, LBU/LHU zero-extend), register into dmem_out, go to DONE.
  - If counter reaches TIMEOUT-1 without rvalid: dmem_out = 0, bus_err = 1 (sticky until rst), go to DONE.
- DONE:
  - One cycle; stall = 0, so the pipeline advances at this clock edge.
  - misalign = 1 in this cycle only if entered via an exception (dmem_out = 0).
  - Always returns to IDLE; a new op is never started from DONE, which prevents re-launching the still-visible frozen op.
- Store does not modify dmem_out.
- Load-use latency: minimum 3 cycles (IDLE → REQ → DONE with gnt and rvalid in the same cycle).

Test Plan:
- LW addr 0x100, gnt at cycle 1, rvalid at cycle 3 with rdata 0xDEADBEEF → stall high for 4 cycles, dmem_out = 0xDEADBEEF in DONE, bus_addr = 0x100, be = 1111.
- LB addr 0x103, rdata 0x80FF_0000 → dmem_out = 0xFFFFFF80. LBU same → 0x00000080. LH addr 0x102 → 0xFFFF80FF.
- SB addr 0x201, rs2 = 0x12345678, gnt delayed 2 cycles → req/addr 0x200/be 0010/wdata 0x78787878 held stable 3 cycles, then DONE; dmem_out unchanged.
- LW addr 0x102 → no bus_req, misalign pulses 1 cycle, dmem_out = 0, stall for exactly 1 cycle. func3 = 011 load → same response.
- Load granted, rvalid never arrives, TIMEOUT = 4 → DONE after 4 WAIT cycles, bus_err = 1 and still 1 after later ops, dmem_out = 0.
- rst asserted during WAIT → same-cycle bus_req = 0, state IDLE, all outputs 0; rvalid one cycle later has no effect on dmem_out.

Source files
------------

// File: rtl/r200lsu.sv
// r200 MEM-stage load/store unit: drives a req/gnt/rvalid data bus and stalls
// the pipeline while a transaction is outstanding.
module r200lsu #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_memrd,
    input  logic        mem_memwr,
    input  logic [2:0]  mem_func3,
    input  logic [31:0] mem_alu_res,
    input  logic [31:0] mem_rs2o,
    output logic [31:0] dmem_out,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t           state, state_nx;
    logic [2:0]       func3_q;
    logic [1:0]       off_q;
    logic [CNT_W-1:0] cnt;
    logic             start, is_st, legal, aligned;
    logic             lat_en, exc, cap, tmo;

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000:  return 4'b0001 << off;
            3'b001:  return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        case (f3)
            3'b000:  return {4{rs2[7:0]}};
            3'b001:  return {2{rs2[15:0]}};
            default: return rs2;
        endcase
    endfunction

    // Pick the addressed lane and sign/zero-extend it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] off,
                                                input logic [2:0] f3);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = rdata[{off, 3'b000} +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  return 32'(b);
            3'b001:  return 32'(h);
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return rdata;
        endcase
    endfunction

    assign start = mem_valid & (mem_memrd | mem_memwr);
    assign is_st = mem_memwr;
    assign legal = is_st ? (mem_func3 inside {3'b000, 3'b001, 3'b010})
                         : (mem_func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});

    always_comb begin
        aligned = 1'b1;
        case (mem_func3[1:0])
            2'b01:   aligned = ~mem_alu_res[0];
            2'b10:   aligned = (mem_alu_res[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        bus_req  = 1'b0;
        lat_en   = 1'b0;
        exc      = 1'b0;
        cap      = 1'b0;
        tmo      = 1'b0;
        case (state)
            IDLE: begin
                stall = start;
                if (start) begin
                    if (legal && aligned) begin
                        lat_en   = 1'b1;
                        state_nx = REQ;
                    end else begin
                        exc      = 1'b1;
                        state_nx = DONE;
                    end
                end
            end
            REQ: begin
                stall   = 1'b1;
                bus_req = 1'b1;
                if (bus_gnt) begin
                    if (bus_we) begin
                        state_nx = DONE;
                    end else if (bus_rvalid) begin
                        cap      = 1'b1;
                        state_nx = DONE;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (bus_rvalid) begin
                    cap      = 1'b1;
                    state_nx = DONE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    tmo      = 1'b1;
                    state_nx = DONE;
                end
            end
            // DONE never launches a new op: the frozen op is still visible on the inputs.
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            func3_q   <= '0;
            off_q     <= '0;
            cnt       <= '0;
            dmem_out  <= '0;
            misalign  <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            if (lat_en) begin
                bus_we    <= is_st;
                bus_addr  <= {mem_alu_res[31:2], 2'b00};
                bus_be    <= is_st ? store_be(mem_func3, mem_alu_res[1:0]) : 4'b1111;
                bus_wdata <= store_wdata(mem_func3, mem_rs2o);
                func3_q   <= mem_func3;
                off_q     <= mem_alu_res[1:0];
            end
            if (state == REQ)       cnt <= '0;
            else if (state == WAIT) cnt <= cnt + 1'b1;
            if (cap)              dmem_out <= load_extend(bus_rdata, off_q, func3_q);
            else if (exc || tmo)  dmem_out <= '0;
            misalign <= exc;
            bus_err  <= bus_err | tmo;
        end
    end

endmodule
